key_conditioner: RTL
====================

Name: key_conditioner

Overview:
Front-end input stage that sits directly upstream of the multiply/accumulate control top. It synchronises and debounces the raw board pushbutton and switches, turns the update key into a toggle level plus a one-cycle pulse, and range-checks the max_num switch value. A validated operand is offered to the control stage over a valid/ready handshake. This replaces the top's direct use of the raw key as a clock edge.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before a debounced output changes (10 ms at 100 MHz)
NUM_W, 6, width of the operand switch bus and of num_data
LIMIT_ONE, 30, largest legal operand value; 0 is always illegal

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
update_key  in  1  raw update pushbutton, asynchronous, bouncy
cont_sw  in  1  raw run/stop switch
max_sw  in  NUM_W  raw operand switches
cont_set  out  1  debounced run/stop level
update  out  1  toggle level; flips on each debounced key press
update_pulse  out  1  one-cycle pulse on each debounced key press
num_valid  out  1  operand offer valid
num_ready  in  1  downstream accepts operand
num_data  out  NUM_W  validated operand
warning  out  1  last captured operand was illegal

Behaviour:
- Reset (rst high at a clk edge): all synchroniser flops, debounced levels, counters, update, update_pulse, num_valid, num_data and warning go to 0. The FSM goes to IDLE. Reset has priority over every other event, including mid-offer.
- Synchronisers: 2-flop synchroniser on update_key, cont_sw and each max_sw bit.
- Debounce, key and cont_sw: each has its own counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised input equals the current debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES, the debounced level takes the input value and the counter clears.
- Debounce, max_sw: one shared counter compares the whole synchronised vector against a held debounced vector. Any bit change restarts the count.
- update_pulse: high exactly one cycle, in the cycle after the debounced key rises. Releasing the key produces no pulse.
- update: toggles in the same cycle update_pulse is high. It is independent of cont_set.
- Load FSM, states IDLE, CHECK, OFFER:
  - IDLE → CHECK: update_pulse=1 and cont_set=1. Capture the debounced max_sw into an internal register.
  - update_pulse with cont_set=0: no capture; update still toggles.
  - CHECK, one cycle: if captured==0 or captured>LIMIT_ONE, set warning=1, num_data=0 and go to IDLE. Otherwise set warning=0, num_data=captured, num_valid=1 and go to OFFER.
  - OFFER: num_valid and num_data are held stable until num_ready=1 is sampled with num_valid=1. In the next cycle num_valid=0 and the FSM returns to IDLE; num_data keeps its value.
  - update_pulse arriving in CHECK or OFFER is ignored for capture (no queueing).
- Latency: pulse at cycle T, CHECK at T+1, num_valid or warning at T+2. If num_ready is already high, num_valid is high for exactly one cycle.
- cont_set low, evaluated each cycle (any state): FSM goes to IDLE, num_valid=0 and warning=0 next cycle. This aborts an offer in progress; no handshake completes.
- Arithmetic: unsigned compare only. Both bounds are inclusive: 1 and LIMIT_ONE are legal.
- Debounce latency from a stable raw edge to the debounced change: 2 (sync) + DEBOUNCE_CYCLES cycles.

Test Plan:
(All with DEBOUNCE_CYCLES=4, NUM_W=6, LIMIT_ONE=30.)
- Reset: rst high 2 cycles with all raw inputs toggling → every output 0, and update_pulse stays 0 for the reset cycles.
- Bounce: update_key toggling every 2 cycles for 20 cycles, then held high → exactly one update_pulse, asserted 7 cycles after the final rise; update 0→1; release → no pulse.
- Legal load: cont_sw=1, max_sw=17, key press, num_ready=0 → num_valid=1 and num_data=17 at T+2, held 5 cycles. num_ready=1 → valid drops the next cycle and FSM returns to IDLE.
- Boundaries: max_sw=0 → warning=1, no valid. 31 → warning=1. 30 → valid, data 30. 1 → valid, data 1, and warning clears.
- Abort and ignore: during OFFER, press key again → no recapture, update toggles. Then drop cont_sw → 6 cycles later cont_set=0, and the next cycle num_valid=0, warning=0.
- Mid-operation reset: rst asserted in OFFER with num_ready=0 → next cycle num_valid=0, num_data=0, update=0, FSM in IDLE.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner
//
// Input stage ahead of the multiply/accumulate control block. Synchronises and
// debounces the raw pushbutton and switches, derives a toggle level and a
// one-cycle pulse from the update key, and range-checks the operand switches.
// A legal operand is offered downstream over a valid/ready handshake.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_update_key   raw update pushbutton (asynchronous, bouncy)
//   i_cont_sw      raw run/stop switch
//   i_max_sw       raw operand switches, NUM_W bits
//   o_cont_set     debounced run/stop level
//   o_update       toggles on each debounced key press
//   o_update_pulse one-cycle pulse on each debounced key press
//   o_num_valid    operand offer valid
//   i_num_ready    downstream accepts operand
//   o_num_data     validated operand
//   o_warning      last captured operand was illegal (0 or above LIMIT_ONE)

module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned NUM_W           = 6,
  parameter int unsigned LIMIT_ONE       = 30
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_update_key,
  input  logic             i_cont_sw,
  input  logic [NUM_W-1:0] i_max_sw,
  output logic             o_cont_set,
  output logic             o_update,
  output logic             o_update_pulse,
  output logic             o_num_valid,
  input  logic             i_num_ready,
  output logic [NUM_W-1:0] o_num_data,
  output logic             o_warning
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StOffer
  } state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers
  // ---------------------------------------------------------------------------
  logic             r_key_s1, r_key_s2;
  logic             r_cont_s1, r_cont_s2;
  logic [NUM_W-1:0] r_max_s1, r_max_s2;
  // Previous synchronised operand, used to restart the shared count on any change
  logic [NUM_W-1:0] r_max_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_s1   <= 1'b0;
      r_key_s2   <= 1'b0;
      r_cont_s1  <= 1'b0;
      r_cont_s2  <= 1'b0;
      r_max_s1   <= '0;
      r_max_s2   <= '0;
      r_max_last <= '0;
    end else begin
      r_key_s1   <= i_update_key;
      r_key_s2   <= r_key_s1;
      r_cont_s1  <= i_cont_sw;
      r_cont_s2  <= r_cont_s1;
      r_max_s1   <= i_max_sw;
      r_max_s2   <= r_max_s1;
      r_max_last <= r_max_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: update key
  // ---------------------------------------------------------------------------
  logic            r_key_db;
  logic [CntW-1:0] r_key_cnt;
  logic [CntW-1:0] w_key_cnt_inc;

  always_comb begin
    w_key_cnt_inc = r_key_cnt + CntOne;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_db  <= 1'b0;
      r_key_cnt <= '0;
    end else if (r_key_s2 == r_key_db) begin
      r_key_cnt <= '0;
    end else if (w_key_cnt_inc == CntMax) begin
      r_key_db  <= r_key_s2;
      r_key_cnt <= '0;
    end else begin
      r_key_cnt <= w_key_cnt_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: run/stop switch
  // ---------------------------------------------------------------------------
  logic            r_cont_db;
  logic [CntW-1:0] r_cont_cnt;
  logic [CntW-1:0] w_cont_cnt_inc;

  always_comb begin
    w_cont_cnt_inc = r_cont_cnt + CntOne;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cont_db  <= 1'b0;
      r_cont_cnt <= '0;
    end else if (r_cont_s2 == r_cont_db) begin
      r_cont_cnt <= '0;
    end else if (w_cont_cnt_inc == CntMax) begin
      r_cont_db  <= r_cont_s2;
      r_cont_cnt <= '0;
    end else begin
      r_cont_cnt <= w_cont_cnt_inc;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: operand switches (one counter for the whole vector)
  // ---------------------------------------------------------------------------
  logic [NUM_W-1:0] r_max_db;
  logic [CntW-1:0]  r_max_cnt;
  logic [CntW-1:0]  w_max_cnt_next;

  // A fresh value counts as its first stable cycle; otherwise keep counting.
  always_comb begin
    w_max_cnt_next = (r_max_s2 != r_max_last) ? CntOne : (r_max_cnt + CntOne);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_max_db  <= '0;
      r_max_cnt <= '0;
    end else if (r_max_s2 == r_max_db) begin
      r_max_cnt <= '0;
    end else if (w_max_cnt_next == CntMax) begin
      r_max_db  <= r_max_s2;
      r_max_cnt <= '0;
    end else begin
      r_max_cnt <= w_max_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Key press pulse and toggle level
  // ---------------------------------------------------------------------------
  logic r_key_db_d;
  logic r_update_pulse;
  logic r_update;
  logic w_key_rise;

  always_comb begin
    w_key_rise = r_key_db & ~r_key_db_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_db_d     <= 1'b0;
      r_update_pulse <= 1'b0;
      r_update       <= 1'b0;
    end else begin
      r_key_db_d     <= r_key_db;
      r_update_pulse <= w_key_rise;
      if (w_key_rise) begin
        r_update <= ~r_update;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  state_e           r_state, w_state_d;
  logic [NUM_W-1:0] r_cap, w_cap_d;
  logic [NUM_W-1:0] r_num_data, w_num_data_d;
  logic             r_num_valid, w_num_valid_d;
  logic             r_warning, w_warning_d;
  logic             w_cap_illegal;

  always_comb begin
    w_cap_illegal = (r_cap == '0) || (32'(r_cap) > LIMIT_ONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cap       <= '0;
      r_num_data  <= '0;
      r_num_valid <= 1'b0;
      r_warning   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cap       <= w_cap_d;
      r_num_data  <= w_num_data_d;
      r_num_valid <= w_num_valid_d;
      r_warning   <= w_warning_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_cap_d       = r_cap;
    w_num_data_d  = r_num_data;
    w_num_valid_d = r_num_valid;
    w_warning_d   = r_warning;

    if (!r_cont_db) begin
      // Stop aborts whatever is in flight; no handshake completes.
      w_state_d     = StIdle;
      w_num_valid_d = 1'b0;
      w_warning_d   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_update_pulse) begin
            w_cap_d   = r_max_db;
            w_state_d = StCheck;
          end
        end
        StCheck: begin
          if (w_cap_illegal) begin
            w_warning_d  = 1'b1;
            w_num_data_d = '0;
            w_state_d    = StIdle;
          end else begin
            w_warning_d   = 1'b0;
            w_num_data_d  = r_cap;
            w_num_valid_d = 1'b1;
            w_state_d     = StOffer;
          end
        end
        StOffer: begin
          // Pulses arriving here are dropped; data stays put after acceptance.
          if (r_num_valid && i_num_ready) begin
            w_num_valid_d = 1'b0;
            w_state_d     = StIdle;
          end
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_cont_set     = r_cont_db;
    o_update       = r_update;
    o_update_pulse = r_update_pulse;
    o_num_valid    = r_num_valid;
    o_num_data     = r_num_data;
    o_warning      = r_warning;
  end

endmodule
